// File: rtl/pacman_game_ctrl_if.sv
// Game-controller bundle: frame/button/candy strobes and sprite positions in, game status out.
// Latency: none, wires only.
// Backpressure: none; all strobes are single-cycle pulses with no handshake.
interface pacman_game_ctrl_if;
  logic        frame_stb;
  logic        start_btn;
  logic        ate_candy_stb;
  logic        ate_power_cookie_stb;
  logic [8:0]  x_pac;
  logic [8:0]  y_pac;
  logic [35:0] ghost_x;
  logic [35:0] ghost_y;
  logic [2:0]  game_state;
  logic        move_en;
  logic        frightened;
  logic        pos_reset_stb;
  logic        map_reload_stb;
  logic [3:0]  ghost_eaten_stb;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [7:0]  level;

  // Stimulus / field side: drives strobes and positions, observes game status.
  modport master (
    output frame_stb, start_btn, ate_candy_stb, ate_power_cookie_stb,
    output x_pac, y_pac, ghost_x, ghost_y,
    input  game_state, move_en, frightened, pos_reset_stb, map_reload_stb,
    input  ghost_eaten_stb, score, lives, level
  );

  // Controller side.
  modport slave (
    input  frame_stb, start_btn, ate_candy_stb, ate_power_cookie_stb,
    input  x_pac, y_pac, ghost_x, ghost_y,
    output game_state, move_en, frightened, pos_reset_stb, map_reload_stb,
    output ghost_eaten_stb, score, lives, level
  );
endinterface

// File: rtl/pacman_game_ctrl.sv
// Pacman game sequencer: game state, score, lives, level, frightened timer, ghost collision.
// Latency: score/lives/state and all strobes update 1 cycle after the causing input.
// Backpressure: none; inputs are one-cycle strobes. Optional bonus life via PACMAN_EXTRA_LIFE_EN.
module pacman_game_ctrl #(
  parameter int START_LIVES      = 3,
  parameter int TOTAL_CANDIES    = 244,
  parameter int READY_FRAMES     = 120,
  parameter int DEATH_FRAMES     = 90,
  parameter int CLEAR_FRAMES     = 120,
  parameter int POWER_FRAMES     = 360,
  parameter int COLLIDE_DIST     = 6,
  parameter int GHOST_POINTS     = 20,
  parameter int EXTRA_LIFE_SCORE = 1000
) (
  input logic              vga_pix_clk,
  input logic              rst,
  pacman_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DEATH = 3'd3,
    S_CLEAR = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] frame_cnt, frame_cnt_nxt;       // frame_stb pulses seen in the current timed state
  logic [15:0] fright_cnt, fright_cnt_nxt;     // frames of frightened mode remaining
  logic [15:0] candies_left, candies_left_nxt;
  logic [15:0] score_q, score_nxt;
  logic [2:0]  lives_q, lives_nxt;
  logic [7:0]  level_q, level_nxt;
  logic        pos_reset_q, pos_reset_nxt;
  logic        map_reload_q, map_reload_nxt;
  logic [3:0]  ghost_eaten_q, ghost_eaten_nxt;
  logic        start_prev;
  logic        start_edge;
  logic [3:0]  hit;
  logic        death;
  logic [16:0] add;
  logic [16:0] score_sum;
  logic [1:0]  dec;

  logic signed [9:0] dx [4];
  logic signed [9:0] dy [4];
  logic [9:0]        adx [4];
  logic [9:0]        ady [4];

`ifdef PACMAN_EXTRA_LIFE_EN
  logic award, award_nxt;                      // bonus life already granted this game
`else
  logic [15:0] unused_extra_life_score;
  assign unused_extra_life_score = 16'(EXTRA_LIFE_SCORE);
`endif

  assign start_edge = bus.start_btn & ~start_prev;

  // Per-ghost box overlap test using 10-bit signed differences.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dx[i]  = $signed({1'b0, bus.x_pac}) - $signed({1'b0, bus.ghost_x[i*9 +: 9]});
      dy[i]  = $signed({1'b0, bus.y_pac}) - $signed({1'b0, bus.ghost_y[i*9 +: 9]});
      adx[i] = dx[i][9] ? $unsigned(-dx[i]) : $unsigned(dx[i]);
      ady[i] = dy[i][9] ? $unsigned(-dy[i]) : $unsigned(dy[i]);
      hit[i] = (adx[i] < 10'(COLLIDE_DIST)) && (ady[i] < 10'(COLLIDE_DIST));
    end
  end

  // Next-state, counters, score and strobe generation.
  always_comb begin
    state_nxt        = state;
    frame_cnt_nxt    = frame_cnt;
    fright_cnt_nxt   = fright_cnt;
    candies_left_nxt = candies_left;
    score_nxt        = score_q;
    lives_nxt        = lives_q;
    level_nxt        = level_q;
    pos_reset_nxt    = 1'b0;
    map_reload_nxt   = 1'b0;
    ghost_eaten_nxt  = 4'd0;
    death            = 1'b0;
    add              = 17'd0;
    score_sum        = 17'd0;
    dec              = 2'd0;
`ifdef PACMAN_EXTRA_LIFE_EN
    award_nxt        = award;
`endif

    if (bus.frame_stb && (fright_cnt != 16'd0)) fright_cnt_nxt = fright_cnt - 16'd1;

    case (state)
      S_IDLE: begin
        if (start_edge) begin
          score_nxt        = 16'd0;
          lives_nxt        = 3'(START_LIVES);
          level_nxt        = 8'd0;
          // The board is restored together with map_reload_stb.
          candies_left_nxt = 16'(TOTAL_CANDIES);
          fright_cnt_nxt   = 16'd0;
          frame_cnt_nxt    = 16'd0;
          pos_reset_nxt    = 1'b1;
          map_reload_nxt   = 1'b1;
          state_nxt        = S_READY;
`ifdef PACMAN_EXTRA_LIFE_EN
          award_nxt        = 1'b0;
`endif
        end
      end

      S_READY: begin
        if (bus.frame_stb) begin
          if (frame_cnt == 16'(READY_FRAMES - 1)) begin
            frame_cnt_nxt = 16'd0;
            state_nxt     = S_PLAY;
          end else begin
            frame_cnt_nxt = frame_cnt + 16'd1;
          end
        end
      end

      S_PLAY: begin
        dec = {1'b0, bus.ate_candy_stb} + {1'b0, bus.ate_power_cookie_stb};
        candies_left_nxt = (candies_left > 16'(dec)) ? candies_left - 16'(dec) : 16'd0;
        if (bus.ate_candy_stb) add = add + 17'd1;
        if (bus.ate_power_cookie_stb) begin
          add            = add + 17'd5;
          fright_cnt_nxt = 16'(POWER_FRAMES);
        end
        // Frightened status at the collision frame is the pre-update counter.
        if (bus.frame_stb) begin
          for (int i = 0; i < 4; i++) begin
            if (hit[i]) begin
              if (fright_cnt != 16'd0) begin
                ghost_eaten_nxt[i] = 1'b1;
                add                = add + 17'(GHOST_POINTS);
              end else begin
                death = 1'b1;
              end
            end
          end
        end
        score_sum = {1'b0, score_q} + add;
        score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`ifdef PACMAN_EXTRA_LIFE_EN
        if (!award && (score_q < 16'(EXTRA_LIFE_SCORE)) && (score_nxt >= 16'(EXTRA_LIFE_SCORE))) begin
          award_nxt = 1'b1;
          if (lives_nxt != 3'd7) lives_nxt = lives_nxt + 3'd1;
        end
`endif
        // Death outranks a board clear detected in the same cycle.
        if (death) begin
          if (lives_nxt != 3'd0) lives_nxt = lives_nxt - 3'd1;
          fright_cnt_nxt = 16'd0;
          frame_cnt_nxt  = 16'd0;
          state_nxt      = S_DEATH;
        end else if (candies_left == 16'd0) begin
          fright_cnt_nxt = 16'd0;
          frame_cnt_nxt  = 16'd0;
          state_nxt      = S_CLEAR;
        end
      end

      S_DEATH: begin
        if (bus.frame_stb) begin
          if (frame_cnt == 16'(DEATH_FRAMES - 1)) begin
            frame_cnt_nxt = 16'd0;
            if (lives_q == 3'd0) begin
              state_nxt = S_OVER;
            end else begin
              pos_reset_nxt = 1'b1;
              state_nxt     = S_READY;
            end
          end else begin
            frame_cnt_nxt = frame_cnt + 16'd1;
          end
        end
      end

      S_CLEAR: begin
        if (bus.frame_stb) begin
          if (frame_cnt == 16'(CLEAR_FRAMES - 1)) begin
            frame_cnt_nxt    = 16'd0;
            level_nxt        = level_q + 8'd1;
            candies_left_nxt = 16'(TOTAL_CANDIES);
            map_reload_nxt   = 1'b1;
            pos_reset_nxt    = 1'b1;
            state_nxt        = S_READY;
          end else begin
            frame_cnt_nxt = frame_cnt + 16'd1;
          end
        end
      end

      S_OVER: begin
        if (start_edge) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; start_prev tracks the button even in reset so a held level never starts a game.
  always_ff @(posedge vga_pix_clk) begin
    start_prev <= bus.start_btn;
    if (rst) begin
      state         <= S_IDLE;
      frame_cnt     <= 16'd0;
      fright_cnt    <= 16'd0;
      candies_left  <= 16'(TOTAL_CANDIES);
      score_q       <= 16'd0;
      lives_q       <= 3'(START_LIVES);
      level_q       <= 8'd0;
      pos_reset_q   <= 1'b0;
      map_reload_q  <= 1'b0;
      ghost_eaten_q <= 4'd0;
    end else begin
      state         <= state_nxt;
      frame_cnt     <= frame_cnt_nxt;
      fright_cnt    <= fright_cnt_nxt;
      candies_left  <= candies_left_nxt;
      score_q       <= score_nxt;
      lives_q       <= lives_nxt;
      level_q       <= level_nxt;
      pos_reset_q   <= pos_reset_nxt;
      map_reload_q  <= map_reload_nxt;
      ghost_eaten_q <= ghost_eaten_nxt;
    end
  end

`ifdef PACMAN_EXTRA_LIFE_EN
  // Bonus-life award flag, cleared at reset and at each game start.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) award <= 1'b0;
    else     award <= award_nxt;
  end
`endif

  assign bus.game_state      = state;
  assign bus.move_en         = (state == S_PLAY);
  assign bus.frightened      = (fright_cnt != 16'd0);
  assign bus.pos_reset_stb   = pos_reset_q;
  assign bus.map_reload_stb  = map_reload_q;
  assign bus.ghost_eaten_stb = ghost_eaten_q;
  assign bus.score           = score_q;
  assign bus.lives           = lives_q;
  assign bus.level           = level_q;

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Bench for pacman_game_ctrl: directed game scenario, spec-level model compared every cycle,
// plus literal spot checks. Small board (10 candies) and bonus threshold 10 keep the run short.
module tb_pacman_game_ctrl;
  localparam int TC = 10;
  localparam int SL = 3;
  localparam int RF = 120;
  localparam int DF = 90;
  localparam int CF = 120;
  localparam int PF = 360;
  localparam int CD = 6;
  localparam int GP = 20;
  localparam int XL = 10;
`ifdef PACMAN_EXTRA_LIFE_EN
  localparam int BONUS = 1;
`else
  localparam int BONUS = 0;
`endif

  logic vga_pix_clk = 1'b0;
  logic rst = 1'b1;
  always #5 vga_pix_clk = ~vga_pix_clk;

  pacman_game_ctrl_if bus ();

  pacman_game_ctrl #(
    .START_LIVES(SL), .TOTAL_CANDIES(TC), .READY_FRAMES(RF), .DEATH_FRAMES(DF),
    .CLEAR_FRAMES(CF), .POWER_FRAMES(PF), .COLLIDE_DIST(CD), .GHOST_POINTS(GP),
    .EXTRA_LIFE_SCORE(XL)
  ) dut (
    .vga_pix_clk(vga_pix_clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model of the game as the rules describe it.
  int   m_state, m_score, m_lives, m_level, m_cand, m_frames, m_fright;
  logic [3:0] m_eat;
  bit   m_pos, m_map, m_prev, m_award;

  function automatic bit near(input int a, input int b);
    int d;
    d = a - b;
    if (d < 0) d = -d;
    return d < CD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit edge_s, death, fr_was;
    int add, old, cand_was, gx, gy;
    edge_s = bus.start_btn && !m_prev;
    m_prev = bus.start_btn;
    m_pos = 0; m_map = 0; m_eat = 4'd0;
    if (rst) begin
      m_state = 0; m_score = 0; m_lives = SL; m_level = 0; m_cand = TC;
      m_frames = 0; m_fright = 0; m_award = 0;
    end else begin
      case (m_state)
        0: if (edge_s) begin
          m_score = 0; m_lives = SL; m_level = 0; m_cand = TC; m_fright = 0; m_award = 0;
          m_pos = 1; m_map = 1; m_frames = 0; m_state = 1;
        end
        1: if (bus.frame_stb) begin
          m_frames++;
          if (m_frames == RF) begin m_frames = 0; m_state = 2; end
        end
        2: begin
          fr_was = (m_fright != 0);
          cand_was = m_cand;
          add = 0; death = 0;
          if (bus.ate_candy_stb) begin add += 1; if (m_cand > 0) m_cand--; end
          if (bus.ate_power_cookie_stb) begin add += 5; if (m_cand > 0) m_cand--; end
          if (bus.ate_power_cookie_stb) m_fright = PF;
          else if (bus.frame_stb && m_fright > 0) m_fright--;
          if (bus.frame_stb) begin
            for (int i = 0; i < 4; i++) begin
              gx = int'(bus.ghost_x[i*9 +: 9]);
              gy = int'(bus.ghost_y[i*9 +: 9]);
              if (near(int'(bus.x_pac), gx) && near(int'(bus.y_pac), gy)) begin
                if (fr_was) begin m_eat[i] = 1'b1; add += GP; end
                else death = 1;
              end
            end
          end
          old = m_score;
          m_score = old + add;
          if (m_score > 65535) m_score = 65535;
`ifdef PACMAN_EXTRA_LIFE_EN
          if (!m_award && old < XL && m_score >= XL) begin
            m_award = 1;
            if (m_lives < 7) m_lives++;
          end
`endif
          if (death) begin
            if (m_lives > 0) m_lives--;
            m_fright = 0; m_frames = 0; m_state = 3;
          end else if (cand_was == 0) begin
            m_fright = 0; m_frames = 0; m_state = 4;
          end
        end
        3: if (bus.frame_stb) begin
          m_frames++;
          if (m_frames == DF) begin
            m_frames = 0;
            if (m_lives == 0) m_state = 5;
            else begin m_pos = 1; m_state = 1; end
          end
        end
        4: if (bus.frame_stb) begin
          m_frames++;
          if (m_frames == CF) begin
            m_frames = 0; m_level = (m_level + 1) % 256; m_cand = TC;
            m_map = 1; m_pos = 1; m_state = 1;
          end
        end
        default: if (edge_s) m_state = 0;
      endcase
    end
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  initial begin
    forever begin
      @(posedge vga_pix_clk);
      model_step();
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge vga_pix_clk);
      if (cmp_en) begin
        chk("game_state", 32'(bus.game_state), 32'(m_state));
        chk("move_en", 32'(bus.move_en), 32'(m_state == 2));
        chk("frightened", 32'(bus.frightened), 32'(m_fright != 0));
        chk("pos_reset_stb", 32'(bus.pos_reset_stb), 32'(m_pos));
        chk("map_reload_stb", 32'(bus.map_reload_stb), 32'(m_map));
        chk("ghost_eaten_stb", 32'(bus.ghost_eaten_stb), 32'(m_eat));
        chk("score", 32'(bus.score), 32'(m_score));
        chk("lives", 32'(bus.lives), 32'(m_lives));
        chk("level", 32'(bus.level), 32'(m_level));
      end
    end
  end

  task automatic step();
    @(negedge vga_pix_clk);
  endtask

  task automatic frame();
    bus.frame_stb = 1'b1; step();
    bus.frame_stb = 1'b0; step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic candy();
    bus.ate_candy_stb = 1'b1; step();
    bus.ate_candy_stb = 1'b0;
  endtask

  task automatic ghosts_far();
    bus.ghost_x = {4{9'd300}};
    bus.ghost_y = {4{9'd300}};
  endtask

  task automatic red_near();
    bus.ghost_x = {9'd300, 9'd300, 9'd300, 9'd105};
    bus.ghost_y = {9'd300, 9'd300, 9'd300, 9'd100};
  endtask

  initial begin
    bus.frame_stb = 1'b0; bus.ate_candy_stb = 1'b0; bus.ate_power_cookie_stb = 1'b0;
    bus.start_btn = 1'b1;
    bus.x_pac = 9'd100; bus.y_pac = 9'd100;
    ghosts_far();
    rst = 1'b1;
    step(); step();
    cmp_en = 1'b1;
    chk("pin_reset_state", 32'(bus.game_state), 0);
    chk("pin_reset_lives", 32'(bus.lives), 3);
    chk("pin_reset_score", 32'(bus.score), 0);

    // Button held through reset must not start a game.
    rst = 1'b0; step(); step(); step();
    chk("pin_held_no_start", 32'(bus.game_state), 0);
    bus.start_btn = 1'b0; step();
    bus.start_btn = 1'b1; step();
    chk("pin_start_state", 32'(bus.game_state), 1);
    chk("pin_start_pos", 32'(bus.pos_reset_stb), 1);
    chk("pin_start_map", 32'(bus.map_reload_stb), 1);
    bus.start_btn = 1'b0; step();
    chk("pin_pos_one_cycle", 32'(bus.pos_reset_stb), 0);

    frames(RF - 1);
    chk("pin_ready_119", 32'(bus.game_state), 1);
    frame();
    chk("pin_play", 32'(bus.game_state), 2);
    chk("pin_move_en", 32'(bus.move_en), 1);

    // Three candies then a power cookie: 3 + 5.
    candy(); candy(); candy();
    bus.ate_power_cookie_stb = 1'b1; step();
    bus.ate_power_cookie_stb = 1'b0;
    chk("pin_score_8", 32'(bus.score), 8);
    chk("pin_fright_on", 32'(bus.frightened), 1);

    // Blue and pink within reach while frightened.
    bus.ghost_x = {9'd95, 9'd300, 9'd103, 9'd300};
    bus.ghost_y = {9'd105, 9'd300, 9'd98, 9'd300};
    bus.frame_stb = 1'b1; step();
    chk("pin_eaten", 32'(bus.ghost_eaten_stb), 32'b1010);
    chk("pin_score_48", 32'(bus.score), 48);
    chk("pin_eat_stays_play", 32'(bus.game_state), 2);
    bus.frame_stb = 1'b0; ghosts_far(); step();
    chk("pin_eaten_cleared", 32'(bus.ghost_eaten_stb), 0);
    frames(PF - 2);
    chk("pin_fright_last", 32'(bus.frightened), 1);
    frame();
    chk("pin_fright_off", 32'(bus.frightened), 0);

    // Red within 5 px, not frightened: death.
    red_near();
    bus.frame_stb = 1'b1; step();
    chk("pin_death", 32'(bus.game_state), 3);
    chk("pin_lives_dec", 32'(bus.lives), 32'(2 + BONUS));
    bus.frame_stb = 1'b0; ghosts_far(); step();
    frames(DF - 1);
    chk("pin_death_hold", 32'(bus.game_state), 3);
    bus.frame_stb = 1'b1; step();
    chk("pin_death_ready", 32'(bus.game_state), 1);
    chk("pin_death_pos", 32'(bus.pos_reset_stb), 1);
    bus.frame_stb = 1'b0; step();
    frames(RF);

    // Clear the remaining 6 candies.
    for (int i = 0; i < TC - 4; i++) candy();
    chk("pin_still_play", 32'(bus.game_state), 2);
    step();
    chk("pin_clear", 32'(bus.game_state), 4);
    frames(CF - 1);
    bus.frame_stb = 1'b1; step();
    chk("pin_clear_ready", 32'(bus.game_state), 1);
    chk("pin_level_1", 32'(bus.level), 1);
    chk("pin_clear_map", 32'(bus.map_reload_stb), 1);
    bus.frame_stb = 1'b0; step();
    frames(RF);

    // Last candy together with a fatal collision: death wins, candy still scores.
    for (int i = 0; i < TC - 1; i++) candy();
    red_near();
    bus.ate_candy_stb = 1'b1; bus.frame_stb = 1'b1; step();
    chk("pin_death_wins", 32'(bus.game_state), 3);
    chk("pin_score_64", 32'(bus.score), 64);
    chk("pin_lives_1", 32'(bus.lives), 32'(1 + BONUS));
    bus.ate_candy_stb = 1'b0; bus.frame_stb = 1'b0; ghosts_far(); step();

    // Keep dying until game over, bounded.
    begin
      int k = 0;
      while (bus.game_state !== 3'd5 && k < 3000) begin
        if (bus.game_state === 3'd2) red_near(); else ghosts_far();
        frame();
        k++;
      end
    end
    ghosts_far();
    chk("pin_over", 32'(bus.game_state), 5);
    chk("pin_over_lives", 32'(bus.lives), 0);
    chk("pin_over_score", 32'(bus.score), 64);

    bus.start_btn = 1'b1; step();
    chk("pin_over_idle", 32'(bus.game_state), 0);
    bus.start_btn = 1'b0; step();
    bus.start_btn = 1'b1; step();
    chk("pin_restart_score", 32'(bus.score), 0);
    chk("pin_restart_lives", 32'(bus.lives), 3);
    bus.start_btn = 1'b0;
    frames(RF);
    candy(); candy();
    red_near();
    frame();
    ghosts_far();
    frames(5);
    chk("pin_in_death", 32'(bus.game_state), 3);

    // Reset in the middle of DEATH, with the button held.
    rst = 1'b1; bus.start_btn = 1'b1; step();
    chk("pin_rst_state", 32'(bus.game_state), 0);
    chk("pin_rst_score", 32'(bus.score), 0);
    chk("pin_rst_lives", 32'(bus.lives), 3);
    rst = 1'b0; step(); step();
    chk("pin_rst_held", 32'(bus.game_state), 0);
    bus.start_btn = 1'b0; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
